fp6_add_arbiter: RTL and testbench
==================================

# fp6_add_arbiter

Round-robin scheduler that shares one pipelined FP6 adder (compare/shift → add → normalise) between `NREQ` requesters. Accepts operand pairs with a valid/ready handshake and issues at most one pair per cycle to the adder. Carries each issue's requester tag through a `LAT`-deep shadow pipeline so the adder result returns to the originating requester. A small control FSM supports enable, drain-to-empty and a drain-complete pulse for the MAC controller above it.

## Interface
- `NREQ`, 4 — number of requesters (2..8)
- `LAT`, 3 — adder latency: cycles from `add_valid` high to matching `add_res` (≥1)
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — synchronous, active-high reset
- `en` in 1 — permits IDLE→RUN
- `drain_req` in 1 — stop accepting, empty pipeline
- `req_valid` in NREQ — per-requester operand pair valid
- `req_a` in 6*NREQ — operand A per requester, {s,e[2:0],m[1:0]}, requester i at [6i+5:6i]
- `req_b` in 6*NREQ — operand B, same packing
- `req_ready` out NREQ — one-hot grant; handshake = valid&ready
- `add_valid` out 1 — issue strobe to adder
- `add_a`, `add_b` out 6 each — operands to adder (s1/e1/m1, s2/e2/m2)
- `add_res` in 6 — adder sum, valid LAT cycles after `add_valid`
- `rsp_valid` out NREQ — one-hot result strobe, no backpressure
- `rsp_data` out 6 — result; 0 when no `rsp_valid` bit set
- `busy` out 1 — in-flight count ≠ 0
- `drain_done` out 1 — one-cycle pulse

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset → IDLE.
- IDLE: no grants; `en`=1 → RUN.
- RUN: grant. `drain_req`=1 → DRAIN, no grant that cycle (drain wins). `en`=0 → IDLE, no grant that cycle.
- DRAIN: no grants; in-flight count 0 → DONE.
- DONE: `drain_done`=1; → IDLE next cycle.
- Arbitration: round-robin over `req_valid` starting at index `ptr`. On handshake with requester g, `ptr` ← (g+1) mod NREQ. `ptr` = 0 after reset. Non-granted requesters hold their operands.
- `req_ready` is combinational from state, `ptr` and `req_valid`. At most one bit is set, and only on a valid requester.
- Tag pipe: LAT+1 entries of {valid, tag[clog2 NREQ]}. Entry 0 is loaded with the handshake. The last entry drives `rsp_valid` = valid ? onehot(tag) : 0.
- In-flight counter, width clog2(LAT+2): +1 on handshake, −1 on response, unchanged when both occur. Maximum LAT+1. Overflow is impossible by construction.
- Responses are never stalled. Requesters must accept `rsp_valid` in the cycle it is asserted.

## Timing
- Handshake at cycle T. `add_valid`/`add_a`/`add_b` registered at T+1. `rsp_valid`/`rsp_data` at T+1+LAT.
- Throughput: one issue per cycle, sustained.
- Reset values: `req_ready`=0, `add_valid`=0, `add_a`=`add_b`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0, `drain_done`=0. `ptr`=0, tag pipe cleared, counter 0.
- `add_a`/`add_b` hold their last values when `add_valid`=0.
- Reset mid-operation: all in-flight tags are discarded. The adder's later outputs produce no `rsp_valid`.
- `drain_req` in IDLE: ignored. `drain_req` with counter already 0: RUN→DRAIN→DONE→IDLE, `drain_done` 2 cycles after the request.
- Simultaneous response and handshake in the same cycle are both honoured.

## Structure
- Package `fp6_pkg`:
  - `fp6_t` packed struct {sign, exp[2:0], man[1:0]}
  - `FP6_W`=6
  - FSM state enum
  - `clog2` helper
- Sub-module `rr_arbiter` (NREQ): inputs `req`, `ptr`; output one-hot `gnt`. The `ptr` update stays in the parent.
- Tag pipe, counter and FSM stay in `fp6_add_arbiter`.

## Test plan
- Single request: LAT=3, requester 2 sends a=6'b0_010_10, b=6'b0_010_01 at cycle 5 → `add_valid` at 6 with those operands. Bench adder stub returns 6'b0_011_10 at 9 → `rsp_valid`=4'b0100, `rsp_data`=6'b0_011_10 at 9.
- All four requesters valid continuously from reset+RUN → grants 0,1,2,3,0… on consecutive cycles. 8 responses return in the same order, tags matching. `busy` stays 1 throughout the burst.
- `drain_req` while 3 ops are in flight → no further `req_ready`. `busy` falls when the last response returns. `drain_done` pulses the next cycle, then the FSM is in IDLE.
- `rst` asserted with 2 ops in flight → all outputs 0 next cycle. The stub's later results produce no `rsp_valid`. `ptr` restarts at 0.
- `en`=0 with `req_valid`=4'b1111 → `req_ready` stays 0 and `add_valid` stays 0. Raising `en` → first grant to requester 0 one cycle later.
- Handshake and response in the same cycle at count 2 → count stays 2. A response with no handshake → count 1. A handshake with no response → count 3.

Source files
------------

// File: rtl/fp6_pkg.sv
// Shared types and helpers for the FP6 adder arbiter.
package fp6_pkg;

  localparam int unsigned FP6_W = 6;

  // FP6 operand layout: sign, 3-bit exponent, 2-bit mantissa.
  typedef struct packed {
    logic       sign;
    logic [2:0] exp;
    logic [1:0] man;
  } fp6_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Ceiling log2, never less than 1 so derived vectors are at least one bit wide.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fp6_add_arbiter_rr_arbiter.sv
// Round-robin priority pick: first valid request at or after ptr, wrapping.
module rr_arbiter
  import fp6_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]          req,
  input  logic [clog2(NREQ)-1:0]   ptr,
  output logic [NREQ-1:0]          gnt
);

  logic found;

  // Two passes: indices >= ptr first, then wrap around from 0.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i >= 32'(ptr))) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp6_add_arbiter.sv
// Shares one pipelined FP6 adder between NREQ requesters; routes results back by tag.
module fp6_add_arbiter
  import fp6_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    drain_req,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [FP6_W*NREQ-1:0]   req_a,
  input  logic [FP6_W*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    add_valid,
  output logic [FP6_W-1:0]        add_a,
  output logic [FP6_W-1:0]        add_b,
  input  logic [FP6_W-1:0]        add_res,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [FP6_W-1:0]        rsp_data,
  output logic                    busy,
  output logic                    drain_done
);

  localparam int unsigned TW = clog2(NREQ);
  localparam int unsigned CW = clog2(LAT + 2);

  state_t          state;
  logic [TW-1:0]   ptr;
  logic [NREQ-1:0] arb_gnt;
  logic            grant_ok;
  logic            hs;
  logic            rsp;
  logic [TW-1:0]   gidx;
  fp6_t            sel_a;
  fp6_t            sel_b;
  logic [CW-1:0]   cnt;
  logic            tv [LAT+1];
  logic [TW-1:0]   tt [LAT+1];

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (arb_gnt)
  );

  // Grants only in RUN, and not in a cycle that leaves RUN.
  assign grant_ok  = (state == ST_RUN) && en && !drain_req;
  assign req_ready = grant_ok ? arb_gnt : '0;
  assign hs        = |req_ready;
  assign rsp       = tv[LAT];
  assign busy      = (cnt != '0);
  assign rsp_data  = tv[LAT] ? add_res : '0;

  // Encode the granted index and select its operands.
  always_comb begin
    gidx  = '0;
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        gidx  = TW'(i);
        sel_a = req_a[FP6_W*i +: FP6_W];
        sel_b = req_b[FP6_W*i +: FP6_W];
      end
    end
  end

  // Decode the tag leaving the shadow pipe into a one-hot response strobe.
  always_comb begin
    rsp_valid = '0;
    if (tv[LAT]) rsp_valid[tt[LAT]] = 1'b1;
  end

  // Control FSM, issue register, tag shadow pipe and in-flight counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      cnt        <= '0;
      add_valid  <= 1'b0;
      add_a      <= '0;
      add_b      <= '0;
      drain_done <= 1'b0;
      for (int unsigned i = 0; i <= LAT; i++) begin
        tv[i] <= 1'b0;
        tt[i] <= '0;
      end
    end else begin
      drain_done <= 1'b0;
      case (state)
        ST_IDLE:  if (en) state <= ST_RUN;
        ST_RUN: begin
          if (drain_req)  state <= ST_DRAIN;
          else if (!en)   state <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (cnt == '0) begin
            state      <= ST_DONE;
            drain_done <= 1'b1;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase

      add_valid <= hs;
      if (hs) begin
        add_a <= sel_a;
        add_b <= sel_b;
        ptr   <= (32'(gidx) == NREQ - 1) ? '0 : gidx + TW'(1);
      end

      tv[0] <= hs;
      tt[0] <= gidx;
      for (int unsigned i = 1; i <= LAT; i++) begin
        tv[i] <= tv[i-1];
        tt[i] <= tt[i-1];
      end

      case ({hs, rsp})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fp6_add_arbiter.sv
// Directed bench for fp6_add_arbiter with a LAT-cycle adder stub.
`timescale 1ns/1ps
module tb_fp6_add_arbiter;
  import fp6_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en;
  logic                  drain_req;
  logic [NREQ-1:0]       req_valid;
  logic [FP6_W*NREQ-1:0] req_a;
  logic [FP6_W*NREQ-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  add_valid;
  logic [FP6_W-1:0]      add_a;
  logic [FP6_W-1:0]      add_b;
  logic [FP6_W-1:0]      add_res;
  logic [NREQ-1:0]       rsp_valid;
  logic [FP6_W-1:0]      rsp_data;
  logic                  busy;
  logic                  drain_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic             sv [LAT];
  logic [FP6_W-1:0] sd [LAT];

  always #5 clk = ~clk;

  fp6_add_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .drain_req  (drain_req),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .add_valid  (add_valid),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_res    (add_res),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .drain_done (drain_done)
  );

  // Adder stand-in: one known FP6 sum, otherwise a distinguishable 6-bit sum.
  function automatic logic [5:0] adder_model(input logic [5:0] a, input logic [5:0] b);
    if (a == 6'b0_010_10 && b == 6'b0_010_01) return 6'b0_011_10;
    return a + b;
  endfunction

  function automatic logic [5:0] op_a(input int i);
    return {1'b0, 3'(i + 1), 2'(i)};
  endfunction

  function automatic logic [5:0] op_b(input int i);
    return {1'b1, 3'(i), 2'b11};
  endfunction

  // Stub pipeline: result appears LAT cycles after add_valid; all-ones when idle.
  always @(posedge clk) begin
    sv[0] <= add_valid;
    sd[0] <= adder_model(add_a, add_b);
    for (int i = 1; i < LAT; i++) begin
      sv[i] <= sv[i-1];
      sd[i] <= sd[i-1];
    end
  end
  assign add_res = sv[LAT-1] ? sd[LAT-1] : 6'h3F;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[FP6_W*i +: FP6_W] = op_a(i);
      req_b[FP6_W*i +: FP6_W] = op_b(i);
    end
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    rst = 1'b1; en = 1'b0; drain_req = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    outs = 32'({req_ready, add_valid, add_a, add_b, rsp_valid, rsp_data, busy, drain_done});
    n_tests++;
    if (outs !== 32'd0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", outs); end
    n_tests++;
    if (dut.ptr !== 2'd0) begin n_fail++; $display("FAIL reset_ptr got=%0d exp=0", dut.ptr); end
    n_tests++;
    if (dut.state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, ST_IDLE); end
  endtask

  task automatic test_single();
    en = 1'b1;
    tick();
    req_valid = 4'b0100;
    req_a[17:12] = 6'b0_010_10;
    req_b[17:12] = 6'b0_010_01;
    #1;
    n_tests++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0;
    #1;
    n_tests++;
    if ({add_valid, add_a, add_b} !== {1'b1, 6'b0_010_10, 6'b0_010_01}) begin
      n_fail++; $display("FAIL single_issue got=%b %b %b exp=1 001010 001001", add_valid, add_a, add_b);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_tests++;
      if ({rsp_valid, rsp_data, add_valid} !== 11'd0) begin
        n_fail++; $display("FAIL single_quiet got=%b %b %b exp=0", rsp_valid, rsp_data, add_valid);
      end
      n_tests++;
      if ({add_a, add_b} !== {6'b0_010_10, 6'b0_010_01}) begin
        n_fail++; $display("FAIL single_hold got=%b %b exp=001010 001001", add_a, add_b);
      end
    end
    tick();
    n_tests++;
    if ({rsp_valid, rsp_data} !== {4'b0100, 6'b0_011_10}) begin
      n_fail++; $display("FAIL single_rsp got=%b %b exp=0100 001110", rsp_valid, rsp_data);
    end
    tick();
    n_tests++;
    if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_rsp_end got=%b exp=0000", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_rdy, exp_rsp;
    logic [5:0] exp_data;
    logic       exp_busy;
    rst = 1'b1; en = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    load_ops();
    req_valid = 4'b1111;
    for (int c = 0; c <= 12; c++) begin
      if (c == 8) req_valid = '0;
      #1;
      exp_rdy  = (c < 8) ? 4'(1 << (c % 4)) : 4'd0;
      exp_rsp  = (c >= 4 && c < 12) ? 4'(1 << ((c - 4) % 4)) : 4'd0;
      exp_data = (c >= 4 && c < 12) ? adder_model(op_a((c - 4) % 4), op_b((c - 4) % 4)) : 6'd0;
      exp_busy = (c >= 1 && c <= 11);
      n_tests++;
      if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
      n_tests++;
      if (rsp_valid !== exp_rsp) begin n_fail++; $display("FAIL b2b_rsp c=%0d got=%b exp=%b", c, rsp_valid, exp_rsp); end
      n_tests++;
      if (rsp_data !== exp_data) begin n_fail++; $display("FAIL b2b_data c=%0d got=%b exp=%b", c, rsp_data, exp_data); end
      n_tests++;
      if (busy !== exp_busy) begin n_fail++; $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, busy, exp_busy); end
      tick();
    end
  endtask

  task automatic test_drain();
    logic [3:0] exp_rsp;
    req_valid = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (req_ready !== 4'(1 << c)) begin n_fail++; $display("FAIL drain_fill c=%0d got=%b exp=%b", c, req_ready, 4'(1 << c)); end
      tick();
    end
    drain_req = 1'b1;
    req_valid = 4'b1111;
    for (int c = 3; c <= 9; c++) begin
      if (c == 4) drain_req = 1'b0;
      if (c == 9) begin en = 1'b0; req_valid = '0; end
      #1;
      exp_rsp = (c >= 4 && c <= 6) ? 4'(1 << (c - 4)) : 4'd0;
      n_tests++;
      if (req_ready !== 4'd0) begin n_fail++; $display("FAIL drain_ready c=%0d got=%b exp=0000", c, req_ready); end
      n_tests++;
      if (busy !== (c < 7)) begin n_fail++; $display("FAIL drain_busy c=%0d got=%b exp=%b", c, busy, (c < 7)); end
      n_tests++;
      if (drain_done !== (c == 8)) begin n_fail++; $display("FAIL drain_done c=%0d got=%b exp=%b", c, drain_done, (c == 8)); end
      n_tests++;
      if (rsp_valid !== exp_rsp) begin n_fail++; $display("FAIL drain_rsp c=%0d got=%b exp=%b", c, rsp_valid, exp_rsp); end
      if (c == 9) begin
        n_tests++;
        if (dut.state !== ST_IDLE) begin n_fail++; $display("FAIL drain_idle got=%0d exp=%0d", dut.state, ST_IDLE); end
      end
      tick();
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] outs;
    en = 1'b1;
    tick();
    req_valid = 4'b0011;
    #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rstmid_wrap got=%b exp=0001", req_ready); end
    tick();
    #1;
    n_tests++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rstmid_second got=%b exp=0010", req_ready); end
    tick();
    req_valid = '0; rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    outs = 32'({req_ready, add_valid, add_a, add_b, rsp_valid, rsp_data, busy, drain_done});
    n_tests++;
    if (outs !== 32'd0) begin n_fail++; $display("FAIL rstmid_outputs got=%h exp=0", outs); end
    n_tests++;
    if (dut.ptr !== 2'd0) begin n_fail++; $display("FAIL rstmid_ptr got=%0d exp=0", dut.ptr); end
    for (int c = 3; c <= 6; c++) begin
      n_tests++;
      if ({rsp_valid, rsp_data} !== 10'd0) begin
        n_fail++; $display("FAIL rstmid_norsp c=%0d got=%b %b exp=0", c, rsp_valid, rsp_data);
      end
      tick();
    end
  endtask

  task automatic test_enable();
    load_ops();
    req_valid = 4'b1111;
    for (int c = 0; c <= 3; c++) begin
      if (c == 3) en = 1'b1;
      #1;
      n_tests++;
      if ({req_ready, add_valid} !== 5'd0) begin
        n_fail++; $display("FAIL en_off c=%0d got=%b %b exp=0", c, req_ready, add_valid);
      end
      tick();
    end
    #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL en_first got=%b exp=0001", req_ready); end
    tick();
    en = 1'b0;
    #1;
    n_tests++;
    if ({add_valid, add_a, req_ready} !== {1'b1, op_a(0), 4'b0000}) begin
      n_fail++; $display("FAIL en_drop got=%b %b %b exp=1 %b 0000", add_valid, add_a, req_ready, op_a(0));
    end
    tick();
    #1;
    n_tests++;
    if ({req_ready, add_valid} !== 5'd0) begin n_fail++; $display("FAIL en_idle got=%b %b exp=0", req_ready, add_valid); end
    req_valid = '0;
    for (int k = 0; k < 5; k++) tick();
  endtask

  task automatic test_counter();
    int unsigned exp_cnt [13] = '{0, 1, 2, 2, 2, 2, 1, 2, 3, 2, 2, 1, 0};
    en = 1'b1;
    tick();
    for (int c = 0; c <= 12; c++) begin
      case (c)
        0:       req_valid = 4'b0100;
        1:       req_valid = 4'b1000;
        4:       req_valid = 4'b0010;
        6:       req_valid = 4'b0001;
        7:       req_valid = 4'b0100;
        default: req_valid = 4'b0000;
      endcase
      #1;
      n_tests++;
      if (32'(dut.cnt) !== exp_cnt[c]) begin n_fail++; $display("FAIL cnt c=%0d got=%0d exp=%0d", c, dut.cnt, exp_cnt[c]); end
      if (c == 4 || c == 5) begin
        n_tests++;
        if (rsp_valid !== ((c == 4) ? 4'b0100 : 4'b1000)) begin
          n_fail++; $display("FAIL cnt_rsp c=%0d got=%b exp=%b", c, rsp_valid, (c == 4) ? 4'b0100 : 4'b1000);
        end
      end
      tick();
    end
  endtask

  task automatic test_drain_empty();
    drain_req = 1'b1;
    req_valid = 4'b1111;
    #1;
    n_tests++;
    if (req_ready !== 4'd0) begin n_fail++; $display("FAIL dempty_nogrant got=%b exp=0000", req_ready); end
    tick();
    drain_req = 1'b0;
    req_valid = '0;
    #1;
    n_tests++;
    if (drain_done !== 1'b0) begin n_fail++; $display("FAIL dempty_early got=%b exp=0", drain_done); end
    tick();
    en = 1'b0;
    #1;
    n_tests++;
    if (drain_done !== 1'b1) begin n_fail++; $display("FAIL dempty_pulse got=%b exp=1", drain_done); end
    tick();
    drain_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if ({drain_done, dut.state} !== {1'b0, ST_IDLE}) begin
        n_fail++; $display("FAIL dempty_idle c=%0d got=%b %0d exp=0 %0d", c, drain_done, dut.state, ST_IDLE);
      end
      tick();
    end
    drain_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < LAT; i++) begin
      sv[i] = 1'b0;
      sd[i] = '0;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_drain();
    test_reset_midop();
    test_enable();
    test_counter();
    test_drain_empty();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
